// File: rtl/mul_unit_pkg.sv
// mul_unit_pkg: shared definitions for the EX-stage multiply unit.
//   - REG_W_DEFAULT   : default register width (the core's RegW)
//   - MUL_OP_W / mul_op_e : multiply op encoding shared with decode
//   - mul_state_e     : issue/writeback FSM states
//   - helpers that classify an op (high word? unsigned operands?)
package mul_unit_pkg;

  localparam int REG_W_DEFAULT    = 32;
  localparam int MUL_CORE_LATENCY = 2;

  localparam int MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL_W   = 2'b00,
    MUL_OP_MULH_W  = 2'b01,
    MUL_OP_MULH_WU = 2'b10,
    MUL_OP_RSVD    = 2'b11   // executes as MUL_OP_MUL_W
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // High-word ops return product[2*REG_W-1:REG_W]; everything else the low word.
  function automatic logic op_is_high(input mul_op_e op);
    return (op == MUL_OP_MULH_W) || (op == MUL_OP_MULH_WU);
  endfunction

  // Only MULH_WU treats its operands as unsigned.
  function automatic logic op_is_unsigned(input mul_op_e op);
    return (op == MUL_OP_MULH_WU);
  endfunction

endpackage

// File: rtl/mul_core.sv
// mul_core: bare 2-stage signed multiplier.
//   CLK : clock
//   a,b : REG_W+1 bit signed operands (already sign/zero extended)
//   p   : 2*REG_W+2 bit signed product, two edges after a/b are presented
// Operands are registered every cycle, then the product is registered.
// No reset and no enable: the owner tracks which cycle holds a valid product.
module mul_core #(
  parameter int REG_W = 32
) (
  input  logic               CLK,
  input  logic [REG_W:0]     a,
  input  logic [REG_W:0]     b,
  output logic [2*REG_W+1:0] p
);

  logic signed [REG_W:0]     r_a;
  logic signed [REG_W:0]     r_b;
  logic signed [2*REG_W+1:0] r_p;

  always_ff @(posedge CLK) begin
    r_a <= a;
    r_b <= b;
    r_p <= r_a * r_b;
  end

  assign p = r_p;

endmodule

// File: rtl/mul_unit.sv
// mul_unit: EX-stage multiply issue/writeback wrapper around mul_core.
//   CLK, RST            : clock, synchronous active-high reset
//   flush               : kills any in-flight or held op
//   in_valid/in_ready   : request handshake (in_op, in_src1, in_src2, in_rd)
//   out_valid/out_ready : result handshake (out_result, out_rd)
//   busy                : an op is in flight or a result is held
// One op in flight at a time; a held result can retire on the same edge a
// new request is accepted, so back-to-back ops issue with no bubble.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int REG_W   = REG_W_DEFAULT,
  parameter int RD_W    = 5,
  parameter int LATENCY = MUL_CORE_LATENCY  // must equal the mul_core depth (2)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [REG_W-1:0]    in_src1,
  input  logic [REG_W-1:0]    in_src2,
  input  logic [RD_W-1:0]     in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_W-1:0]    out_result,
  output logic [RD_W-1:0]     out_rd,
  output logic                busy
);

  localparam int CNT_W = 1;

  mul_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  mul_op_e             r_op;
  logic [RD_W-1:0]     r_rd;
  logic                r_out_valid;
  logic [RD_W-1:0]     r_out_rd;
  logic [REG_W-1:0]    r_result;
  logic                r_fresh;

  mul_op_e             w_in_op;
  logic                w_accept;
  logic [REG_W:0]      w_a;
  logic [REG_W:0]      w_b;
  logic [2*REG_W+1:0]  w_p;
  logic [REG_W-1:0]    w_sel;
  logic [1:0]          w_unused_p_top;

  assign w_in_op  = mul_op_e'(in_op);
  assign in_ready = !flush && ((r_state == ST_IDLE) ||
                               ((r_state == ST_DONE) && out_ready));
  assign w_accept = in_valid && in_ready;

  // Extension is applied every cycle; the core only matters on accept edges.
  assign w_a = op_is_unsigned(w_in_op) ? {1'b0, in_src1} : {in_src1[REG_W-1], in_src1};
  assign w_b = op_is_unsigned(w_in_op) ? {1'b0, in_src2} : {in_src2[REG_W-1], in_src2};

  mul_core #(
    .REG_W (REG_W)
  ) u_core (
    .CLK (CLK),
    .a   (w_a),
    .b   (w_b),
    .p   (w_p)
  );

  // Bits above 2*REG_W-1 only carry extension; they never reach a result.
  assign w_unused_p_top = w_p[2*REG_W+1:2*REG_W];

  assign w_sel = op_is_high(r_op) ? w_p[2*REG_W-1:REG_W] : w_p[REG_W-1:0];

  // The product register becomes valid on the same edge the FSM enters DONE,
  // so for that first DONE cycle the result comes straight from the core's
  // product register. The core keeps running (no enable), so the selected
  // word is copied into r_result at the end of that cycle and held from
  // then on for as long as writeback stalls.
  assign out_result = r_fresh ? w_sel : r_result;
  assign out_valid  = r_out_valid;
  assign out_rd     = r_out_rd;
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= MUL_OP_MUL_W;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_result    <= '0;
      r_fresh     <= 1'b0;
    end else begin
      r_fresh <= 1'b0;
      if (r_fresh) begin
        r_result <= w_sel;
      end

      if (flush) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_op    <= w_in_op;
              r_rd    <= in_rd;
              r_cnt   <= '0;
              r_state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (r_cnt == CNT_W'(LATENCY - 2)) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_out_rd    <= r_rd;
              r_fresh     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              if (w_accept) begin
                r_op    <= w_in_op;
                r_rd    <= in_rd;
                r_cnt   <= '0;
                r_state <= ST_BUSY;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: scoreboard bench for mul_unit.
// An input monitor pushes the model's expected result on every accepted
// request; an output monitor compares handshake outputs against the queue
// every cycle and pops on retirement. Flush/reset empty the queue.
module tb_mul_unit;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  mul_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;   // edge number at which the request was accepted
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   rand_mode = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference model: full-precision arithmetic, then pick the word.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ps;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      2'b01:   return ps[63:32];
      2'b10:   return pu[63:32];
      default: return pu[31:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Input monitor: records accepts as seen at the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RST && !flush && in_valid && in_ready) begin
        e.res = model(in_op, in_src1, in_src2);
        e.rd  = in_rd;
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  // Output monitor: checks state visible between edges, then applies the
  // events that the upcoming edge will perform on the queue.
  initial begin
    bit exp_v;
    bit exp_rdy;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_v = (q.size() != 0) && (cyc >= q[0].acc + 1);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        if (exp_v && out_valid) begin
          chk("out_result", out_result, q[0].res);
          chk("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
        end
        chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
        exp_rdy = !flush && ((q.size() == 0) || (exp_v && out_ready));
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (flush) begin
          q.delete();
        end else if (exp_v && out_ready) begin
          $display("retire rd=%0d result=%h accepted@%0d", q[0].rd, q[0].res, q[0].acc);
          void'(q.pop_front());
        end
      end else begin
        q.delete();
      end
    end
  end

  // Random backpressure/flush while the random phase runs.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 29) == 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present a request and hold it until accepted; returns 1ns after the accept edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    bit ok;
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_rd    = rd;
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (in_ready && !flush && !RST) begin
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", {31'b0, ok}, 32'd1);
    if (ok) begin
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    @(negedge CLK);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_result"}, out_result, 32'd0);
    chk({tag, "_out_rd"}, {27'b0, out_rd}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    RST       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_src1   = '0;
    in_src2   = '0;
    in_rd     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_outputs("reset");

    // Directed products.
    send(2'b00, 32'd3, 32'd5, 5'd7);
    idle(3);
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    idle(3);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    idle(3);
    send(2'b00, 32'h8000_0000, 32'd2, 5'd3);
    idle(3);
    send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4);
    idle(3);
    send(2'b11, 32'd12345, 32'd678, 5'd31);
    idle(3);

    // Backpressure in DONE, then retire and accept on the same edge.
    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd13, 5'd3);
    idle(5);
    out_ready = 1'b1;
    send(2'b00, 32'd7, 32'd6, 5'd9);
    idle(4);

    // Flush while BUSY: nothing may come out.
    send(2'b00, 32'd9, 32'd9, 5'd1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(5);

    // Flush in DONE with out_ready high and a competing request.
    send(2'b00, 32'd10, 32'd10, 5'd2);
    idle(1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_src1  = 32'd1;
    in_src2  = 32'd1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    idle(4);

    // Reset during BUSY.
    send(2'b00, 32'd100, 32'd200, 5'd5);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check_reset_outputs("midreset");
    idle(4);
    send(2'b00, 32'd2, 32'd2, 5'd6);
    idle(4);

    // Randomized traffic with random backpressure and occasional flush.
    rand_mode = 1;
    for (int n = 0; n < 200; n++) begin
      send(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom));
      idle($urandom_range(0, 2));
    end
    rand_mode = 0;
    idle(1);
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- EX-stage multiply issue/writeback unit.
- Takes one multiply request at a time from the issue stage over a valid/ready handshake.
- Sign- or zero-extends the operands and drives a 2-stage registered multiplier core.
- Selects the low or high word of the full product and presents the result, tagged with its destination register, to writeback over a valid/ready handshake.
- Provides the pipeline stall/flush interface around the bare multiplier.

Parameters:
- REG_W, default `RegW` (32): operand and result width.
- RD_W, default 5: destination register tag width.
- LATENCY, default 2: cycles from accept to out_valid. Fixed by mul_core; any other value is illegal.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; kills the in-flight op.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  2  operation: 00 MUL_W, 01 MULH_W, 10 MULH_WU, 11 reserved (executes as MUL_W).
- in_src1  input  REG_W  operand 1.
- in_src2  input  REG_W  operand 2.
- in_rd  input  RD_W  destination register tag.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- out_result  output  REG_W  selected product word.
- out_rd  output  RD_W  tag of the result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (RST high at posedge):
  - state=IDLE, cnt=0, out_valid=0, out_result=0, out_rd=0, latched op/rd=0.
  - Reset mid-operation discards the op; no out_valid follows.
- States:
  - IDLE: no op in flight.
  - BUSY: waiting on mul_core; cnt counts 0..LATENCY-2.
  - DONE: result held.
- Accept: a request is accepted when in_valid && in_ready at a posedge.
  - in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
  - This allows back-to-back issue: one op in flight, zero bubble on drain.
- Operand extension (combinational into mul_core, every cycle):
  - MULH_WU: zero-extend both operands to REG_W+1.
  - Otherwise: sign-extend both operands to REG_W+1.
- On accept: latch op and rd, state=BUSY, cnt=0.
  - mul_core captures the extended operands at this same edge (edge T).
  - The product is registered at edge T+1.
- BUSY -> DONE when cnt==LATENCY-2, i.e. at edge T+1.
  - At that edge: out_valid=1, out_rd=latched rd, out_result = product[REG_W-1:0] for MUL_W/reserved, else product[2*REG_W-1:REG_W].
  - out_valid is therefore high in the 2nd cycle after the accept cycle.
- DONE:
  - out_valid && out_ready at posedge: result retired.
    - If a new request is accepted at the same edge: state=BUSY.
    - Else: state=IDLE, out_valid=0.
  - Without out_ready: out_result, out_rd and out_valid hold stable.
- flush at posedge (any state): state=IDLE, out_valid=0. No accept occurs that cycle. The pending result is dropped even if out_ready is high.
- Product width is 2*REG_W+2 signed. Bits above 2*REG_W-1 are ignored; no overflow flag.
- RST has priority over flush; flush has priority over accept/retire.

Decomposition:
- Shared header common.vh:
  - existing `RegW`;
  - new macros MUL_OP_W, MUL_OP_MUL_W, MUL_OP_MULH_W, MUL_OP_MULH_WU, so decode and this unit agree.
- Sub-module mul_core:
  - inputs: CLK, a[REG_W:0], b[REG_W:0]; output p[2*REG_W+1:0].
  - Registers operands every cycle, then registers the signed product; no reset, no enable.
- mul_unit holds the FSM, the latches and the word select.

Test Plan:
- MUL_W 3 x 5, rd=7, out_ready=1 -> out_valid exactly 2 cycles after accept, out_result=0x0000000F, out_rd=7, then IDLE.
- MULH_W 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
- MULH_WU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MUL_W 0x80000000 x 2 -> 0x00000000.
- MULH_W 0x80000000 x 0x80000000 -> 0x40000000.
- Back-to-back / backpressure:
  - Hold out_ready=0 for 4 cycles in DONE -> out_result/out_rd stable, in_ready=0.
  - Raise out_ready together with a new in_valid (7 x 6) -> retire and accept on the same edge; 42 appears 2 cycles later.
- Flush:
  - flush in the BUSY cycle -> no out_valid ever.
  - flush in DONE with out_ready=1 -> result dropped, in_ready=0 that cycle, IDLE next.
- Reset mid-op: RST during BUSY -> all outputs 0 next cycle, no stale result after deassertion. A fresh MUL_W 2 x 2 then returns 4.
